serial_tx: RTL and testbench
============================

# serial_tx

Parameterised serial transmitter that frames and shifts out a parallel word one bit per enabled clock. It is the transmit end of the lab's flip-flop-based serial link. A flip-flop-based shift-register receiver samples `tx` on the same `clk` and `enabled` strobe. The block sits between parallel stimulus (switches or a testbench) and that receiver.

## Interface
- `WIDTH`, default 4: number of data bits per frame; legal range 1–16.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `enabled`  in  1: clock enable. When 0, every register holds its value.
- `load`  in  1: request to transmit `data_in`; honoured only in IDLE.
- `data_in`  in  WIDTH: word to transmit; captured on the accepted `load`.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high from the first START cycle through the last STOP cycle.
- `done`  out  1: high for exactly one enabled cycle after a frame completes.

## Operation
- Frame format, in line order: start bit (0), then `WIDTH` data bits LSB first, then an optional parity bit (see Configuration), then one stop bit (1).
- States and encodings: IDLE, START, DATA, PAR, STOP.
- State transitions (all conditioned on `enabled`=1 at the clock edge):
  - IDLE → START when `load`=1. The same edge captures `data_in` into the shift register and clears the bit counter.
  - START → DATA unconditionally.
  - DATA → DATA while bit counter < WIDTH-1. Each DATA edge shifts right one bit and increments the counter.
  - DATA → PAR when the counter = WIDTH-1 and parity is compiled in; otherwise DATA → STOP.
  - PAR → STOP unconditionally.
  - STOP → IDLE unconditionally. This edge sets `done`=1.
- `tx` is registered and equals the bit of the current state:
  - IDLE=1, START=0.
  - DATA = shift-register bit 0.
  - PAR = XOR of the captured word.
  - STOP=1.
- `busy` is 1 in START, DATA, PAR and STOP; it is 0 in IDLE.
- `done` is set only by the STOP → IDLE edge and is cleared by the next enabled edge.
- `load` while `busy`=1 is ignored; `data_in` changes during a frame do not affect that frame.
- Back-to-back frames: a `load`=1 in the IDLE cycle where `done`=1 is accepted. The next START follows with one idle-high cycle between frames.
- Reset values (`reset`=0 at an edge, regardless of `enabled`):
  - state = IDLE, `tx`=1, `busy`=0, `done`=0.
  - Shift register = 0, counter = 0.

## Timing
- Latency from an accepted `load` edge to `tx`=0 (start bit) is one clock.
- Frame length is WIDTH+2 enabled cycles, or WIDTH+3 with parity.
- Every bit occupies exactly one enabled cycle. Cycles with `enabled`=0 stretch the current bit and freeze `done`.
- Reset mid-frame: the next edge returns `tx` to 1 and `busy` to 0. The frame is abandoned and no `done` is produced.
- `load` coincident with `reset`=0: reset wins and nothing is captured.
- WIDTH=1: DATA lasts a single cycle (the counter starts at WIDTH-1).

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - The PAR state is compiled in.
  - An even-parity bit is inserted after the data bits: `tx` = XOR of the captured word, so the total count of ones in data plus parity is even.
  - Frame length is WIDTH+3.
- `SERIAL_TX_PARITY_EN` undefined:
  - The PAR state and parity logic are absent; DATA goes directly to STOP.
  - Frame length is WIDTH+2.

## Test plan
- **Reset:** hold `reset`=0 for 2 edges with `load`=1 → `tx`=1, `busy`=0, `done`=0 and no frame starts. Release reset with `load`=0 → outputs stay idle.
- **Basic frame:** WIDTH=4, no parity, `enabled`=1, `load` pulse with `data_in`=4'b1011.
  - `tx` sequence over 6 cycles is 0,1,1,0,1,1.
  - `busy` is high for those 6 cycles.
  - `done`=1 for one cycle afterwards.
- **Parity build:** with `SERIAL_TX_PARITY_EN`, `data_in`=4'b1011 → `tx` = 0,1,1,0,1,1(parity),1(stop) over 7 cycles. With `data_in`=4'b0011 the parity bit is 0.
- **Busy/back-to-back:**
  - `load` with 4'b0001 mid-frame is ignored and the frame still sends 4'b1011.
  - `load` with 4'b0110 in the `done` cycle → the next frame sends 0,0,1,1,0,1.
- **Enable gating:** drop `enabled` for 3 cycles during data bit 2 → `tx` holds 0 for 4 clocks and frame contents are unchanged.
- **Reset mid-frame:** `reset`=0 during data bit 1 → next edge `tx`=1, `busy`=0. `done` stays 0, and a subsequent `load` sends a complete frame.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: frames a WIDTH-bit word (start, LSB-first data, stop) onto tx.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enabled,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [CW-1:0]    cnt;

`ifdef SERIAL_TX_PARITY_EN
    logic par;
`endif

    // tx is registered, so each DATA edge drives the bit the shift exposes
    assign sh_nxt = sh >> 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (enabled) begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        sh    <= data_in;
                        cnt   <= '0;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= ^data_in;
`endif
                    end
                end
                START: begin
                    state <= DATA;
                    tx    <= sh[0];
                end
                DATA: begin
                    sh  <= sh_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state <= PAR;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        tx <= sh_nxt[0];
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PAR: begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frames with a queued expected-bit scoreboard.
// Build with or without SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enabled;
    logic       load;
    logic [3:0] data_in;
    logic       tx;
    logic       busy;
    logic       done;

    exp_t q[$];
    int   total;
    int   bad;
    bit   mon_on;
    logic exp_done;

    serial_tx #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enabled (enabled),
        .load    (load),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act,
                         input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%b required=%b",
                     name, $time, act, req);
        end
    endtask

    // monitor: outputs are stable at negedge, inputs change at posedge+2
    always @(negedge clk) begin
        logic popped_last;
        popped_last = 1'b0;
        if (mon_on) begin
            check("busy", busy, logic'(q.size() != 0));
            check("done", done, exp_done);
            if (q.size() != 0)
                check("tx_bit", tx, q[0].b);
            else
                check("tx_idle", tx, 1'b1);
            if (!reset) begin
                q.delete();
                exp_done = 1'b0;
            end else if (enabled) begin
                if (q.size() != 0) begin
                    popped_last = q[0].last;
                    void'(q.pop_front());
                end
                exp_done = popped_last;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // p is the hand-computed even parity of d
    task automatic push_frame(input logic [3:0] d, input logic p);
        q.push_back('{b: 1'b0, last: 1'b0});
        for (int i = 0; i < 4; i++)
            q.push_back('{b: d[i], last: 1'b0});
`ifdef SERIAL_TX_PARITY_EN
        q.push_back('{b: p, last: 1'b0});
`else
        if (p === 1'bx) $display("parity unknown");
`endif
        q.push_back('{b: 1'b1, last: 1'b1});
    endtask

    task automatic send(input logic [3:0] d, input logic p);
        data_in = d;
        load    = 1'b1;
        step();
        push_frame(d, p);
        load    = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL wait_idle left=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mon_on   = 1'b0;
        exp_done = 1'b0;
        reset    = 1'b0;
        enabled  = 1'b1;
        load     = 1'b1;
        data_in  = 4'b1111;

        // reset held with load high: nothing may start
        step();
        mon_on = 1'b1;
        step();
        reset = 1'b1;
        load  = 1'b0;
        repeat (3) step();

        // basic frame, ignored mid-frame load, back-to-back in done cycle
        send(4'b1011, 1'b1);
        step();
        step();
        data_in = 4'b0001;
        load    = 1'b1;
        step();
        load    = 1'b0;
        wait_idle();
        send(4'b0110, 1'b0);
        wait_idle();
        repeat (3) step();

        // enable dropped for 3 cycles on data bit 2, then during done
        send(4'b1011, 1'b1);
        repeat (3) step();
        enabled = 1'b0;
        repeat (3) step();
        enabled = 1'b1;
        wait_idle();
        enabled = 1'b0;
        repeat (2) step();
        enabled = 1'b1;
        repeat (2) step();

        // parity-zero word, abandoned by reset on data bit 1
        send(4'b0011, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();
        send(4'b0001, 1'b1);
        wait_idle();
        repeat (3) step();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_end left=%0d required=0", q.size());
        end
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
